rtlupcfgbridge: RTL and testbench

Host-side access sequencer placed directly upstream of a bank of configuration-RAM arbiters. It converts single-cycle host requests into the held-enable / strobe / wait-for-ready protocol the arbiters expect, captures read data, enforces a timeout, and keeps a write-1-to-clear sticky register of per-RAM parity errors. One bridge serves up to `NRAM` arbiters. Address, data and strobes are broadcast to all arbiters; a per-RAM enable selects the target.

---
 rtl/rtlupcfg_pkg.sv | 15 +
 rtl/rtlstkw1c.sv | 31 +++
 rtl/rtlupcfgbridge.sv | 179 +++++++++++++++++
 tb/tb_rtlupcfgbridge.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rtlupcfg_pkg.sv
// Shared definitions for the configuration-RAM access bridge.
// Holds the FSM encoding, the default timeout width and the value returned on a timed-out read.
package rtlupcfg_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    STRB = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int TOBIT_DEFAULT = 6;
  localparam int TIMEOUT_RDATA = 0;

endpackage

// File: rtl/rtlstkw1c.sv
// Sticky status register with write-1-to-clear.
// When a bit is set and cleared in the same cycle, the set wins, so no event is ever lost.
module rtlstkw1c #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] set_bits,
  input  logic         clr_en,
  input  logic [W-1:0] clr_bits,
  output logic [W-1:0] stk
);

  logic [W-1:0] stk_q, stk_d;

  // NOTE: give every combinational output a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    stk_d = stk_q;
    if (clr_en) stk_d = stk_d & ~clr_bits;
    stk_d = stk_d | set_bits;
  end

  // NOTE: use non-blocking assignments here, so every flop samples its pre-edge inputs regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) stk_q <= '0;
    else     stk_q <= stk_d;
  end

  assign stk = stk_q;

endmodule

// File: rtl/rtlupcfgbridge.sv
// Host-side sequencer that turns single-cycle host requests into held-enable / strobe / wait-for-ready
// accesses on a bank of config-RAM arbiters, with a timeout and a sticky parity-error register.
module rtlupcfgbridge
  import rtlupcfg_pkg::*;
#(
  parameter int NRAM    = 4,
  parameter int SELBIT  = 2,
  parameter int ADDRBIT = 5,
  parameter int WIDTH   = 32,
  parameter int TOBIT   = TOBIT_DEFAULT
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cpu_req,
  input  logic                      cpu_wr,
  input  logic                      cpu_regsel,
  input  logic [SELBIT+ADDRBIT-1:0] cpu_addr,
  input  logic [WIDTH-1:0]          cpu_wdata,
  output logic [WIDTH-1:0]          cpu_rdata,
  output logic                      cpu_ack,
  output logic                      cpu_toerr,
  output logic                      cpu_busy,
  output logic [NRAM-1:0]           upen,
  output logic [ADDRBIT-1:0]        upa,
  output logic [WIDTH-1:0]          updi,
  output logic                      upws,
  output logic                      uprs,
  input  logic [NRAM*WIDTH-1:0]     updo,
  input  logic [NRAM-1:0]           uprdy,
  input  logic [NRAM-1:0]           parerr,
  output logic                      parerr_any
);

  state_t               state_q, state_d;
  logic                 wr_q, wr_d;
  logic                 regsel_q, regsel_d;
  logic [SELBIT-1:0]    sel_q, sel_d;
  logic [ADDRBIT-1:0]   addr_q, addr_d;
  logic [WIDTH-1:0]     wdata_q, wdata_d;
  logic [WIDTH-1:0]     rdata_q, rdata_d;
  logic [TOBIT-1:0]     cnt_q, cnt_d;
  logic                 to_q, to_d;

  logic                 accept;
  logic                 rdy_sel;
  logic [TOBIT-1:0]     cnt_inc;
  logic                 timeout;
  logic [NRAM-1:0]      sel_oh;
  logic [WIDTH-1:0]     updo_sel;
  logic [NRAM-1:0]      stk;
  logic [WIDTH-1:0]     stk_ext;
  logic                 stk_clr_en;

  assign accept   = (state_q == IDLE) && cpu_req;
  assign rdy_sel  = uprdy[sel_q];
  assign sel_oh   = NRAM'(1) << sel_q;
  assign updo_sel = updo[int'(sel_q)*WIDTH +: WIDTH];
  // Compare the post-increment count so DONE lands exactly 2^TOBIT-1 cycles after the first WAIT cycle.
  assign cnt_inc  = cnt_q + 1'b1;
  assign timeout  = &cnt_inc;

  always_comb begin
    stk_ext            = '0;
    stk_ext[NRAM-1:0]  = stk;
  end

  assign stk_clr_en = accept && cpu_regsel && cpu_wr;

  rtlstkw1c #(.W(NRAM)) u_stk (
    .clk      (clk),
    .rst      (rst),
    .set_bits (parerr),
    .clr_en   (stk_clr_en),
    .clr_bits (cpu_wdata[NRAM-1:0]),
    .stk      (stk)
  );

  // State register plus holding registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      wr_q     <= 1'b0;
      regsel_q <= 1'b0;
      sel_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      cnt_q    <= '0;
      to_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_q     <= wr_d;
      regsel_q <= regsel_d;
      sel_q    <= sel_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      cnt_q    <= cnt_d;
      to_q     <= to_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (cpu_req) state_d = cpu_regsel ? DONE : STRB;
      STRB:    state_d = WAIT;
      WAIT:    if (rdy_sel || timeout) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wr_d     = wr_q;
    regsel_d = regsel_q;
    sel_d    = sel_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    cnt_d    = cnt_q;
    to_d     = to_q;
    unique case (state_q)
      IDLE: begin
        if (cpu_req) begin
          wr_d     = cpu_wr;
          regsel_d = cpu_regsel;
          sel_d    = cpu_addr[SELBIT+ADDRBIT-1 -: SELBIT];
          addr_d   = cpu_addr[ADDRBIT-1:0];
          wdata_d  = cpu_wdata;
          to_d     = 1'b0;
          // Register reads complete in place; everything else starts with cleared read data.
          rdata_d  = (cpu_regsel && !cpu_wr) ? stk_ext : '0;
        end
      end
      STRB: cnt_d = '0;
      WAIT: begin
        cnt_d = cnt_inc;
        if (rdy_sel) begin
          if (!wr_q) rdata_d = updo_sel;
        end else if (timeout) begin
          to_d    = 1'b1;
          rdata_d = WIDTH'(TIMEOUT_RDATA);
        end
      end
      default: ;
    endcase
  end

  // Output decode from the current state only.
  always_comb begin
    upen      = '0;
    upws      = 1'b0;
    uprs      = 1'b0;
    cpu_ack   = 1'b0;
    cpu_toerr = 1'b0;
    cpu_rdata = '0;
    unique case (state_q)
      STRB: begin
        upen = sel_oh;
        upws = wr_q;
        uprs = !wr_q;
      end
      WAIT: upen = sel_oh;
      DONE: begin
        cpu_ack   = 1'b1;
        cpu_toerr = to_q;
        cpu_rdata = rdata_q;
      end
      default: ;
    endcase
  end

  assign cpu_busy   = (state_q != IDLE);
  assign upa        = addr_q;
  assign updi       = wdata_q;
  assign parerr_any = |stk;

endmodule

// File: tb/tb_rtlupcfgbridge.sv
// Directed self-checking bench for the config-RAM access bridge.
// Each scenario task drives one access and compares outputs cycle by cycle against hand-derived values.
module tb_rtlupcfgbridge;

  localparam int NRAM    = 4;
  localparam int SELBIT  = 2;
  localparam int ADDRBIT = 5;
  localparam int WIDTH   = 32;
  localparam int TOBIT   = 6;

  logic                      clk;
  logic                      rst;
  logic                      cpu_req;
  logic                      cpu_wr;
  logic                      cpu_regsel;
  logic [SELBIT+ADDRBIT-1:0] cpu_addr;
  logic [WIDTH-1:0]          cpu_wdata;
  logic [WIDTH-1:0]          cpu_rdata;
  logic                      cpu_ack;
  logic                      cpu_toerr;
  logic                      cpu_busy;
  logic [NRAM-1:0]           upen;
  logic [ADDRBIT-1:0]        upa;
  logic [WIDTH-1:0]          updi;
  logic                      upws;
  logic                      uprs;
  logic [NRAM*WIDTH-1:0]     updo;
  logic [NRAM-1:0]           uprdy;
  logic [NRAM-1:0]           parerr;
  logic                      parerr_any;

  int n_cmp;
  int n_err;

  rtlupcfgbridge #(
    .NRAM(NRAM), .SELBIT(SELBIT), .ADDRBIT(ADDRBIT), .WIDTH(WIDTH), .TOBIT(TOBIT)
  ) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_regsel(cpu_regsel),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
    .cpu_ack(cpu_ack), .cpu_toerr(cpu_toerr), .cpu_busy(cpu_busy),
    .upen(upen), .upa(upa), .updi(updi), .upws(upws), .uprs(uprs),
    .updo(updo), .uprdy(uprdy), .parerr(parerr), .parerr_any(parerr_any)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge, i.e. into the next cycle.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    cpu_req    = 1'b0;
    cpu_wr     = 1'b0;
    cpu_regsel = 1'b0;
    cpu_addr   = '0;
    cpu_wdata  = '0;
    uprdy      = '0;
    parerr     = '0;
  endtask

  // Drives a register access in the current cycle and returns in its ack cycle.
  task automatic reg_op(input logic wr, input logic [WIDTH-1:0] wd, input logic [NRAM-1:0] pe);
    cpu_req = 1'b1; cpu_wr = wr; cpu_regsel = 1'b1; cpu_wdata = wd; parerr = pe;
    step();
    idle_inputs();
  endtask

  task automatic test_reset();
    idle_inputs();
    updo = '0;
    rst  = 1'b1;
    step(); step(); step();
    n_cmp++; if (cpu_ack !== 1'b0)   begin n_err++; $display("FAIL reset_ack: got %b want 0", cpu_ack); end
    n_cmp++; if (cpu_busy !== 1'b0)  begin n_err++; $display("FAIL reset_busy: got %b want 0", cpu_busy); end
    n_cmp++; if (upen !== 4'b0000)   begin n_err++; $display("FAIL reset_upen: got %b want 0000", upen); end
    n_cmp++; if ({upws, uprs, cpu_toerr, parerr_any} !== 4'b0000)
      begin n_err++; $display("FAIL reset_flags: got %b want 0000", {upws, uprs, cpu_toerr, parerr_any}); end
    n_cmp++; if ({upa, updi, cpu_rdata} !== '0)
      begin n_err++; $display("FAIL reset_data: got %h/%h/%h want 0", upa, updi, cpu_rdata); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_write();
    logic [3:0] exp_upen;
    cpu_req = 1'b1; cpu_wr = 1'b1; cpu_regsel = 1'b0;
    cpu_addr = {2'd2, 5'd5}; cpu_wdata = 32'hA5A5_0001;
    for (int c = 1; c <= 6; c++) begin
      step();
      if (c == 1) begin cpu_req = 1'b0; cpu_addr = '0; cpu_wdata = 32'hFFFF_FFFF; end
      uprdy    = (c == 5) ? 4'b0100 : 4'b0000;
      exp_upen = (c <= 5) ? 4'b0100 : 4'b0000;
      n_cmp++; if (upen !== exp_upen)  begin n_err++; $display("FAIL wr_upen c%0d: got %b want %b", c, upen, exp_upen); end
      n_cmp++; if (upws !== (c == 1))  begin n_err++; $display("FAIL wr_upws c%0d: got %b want %b", c, upws, (c == 1)); end
      n_cmp++; if (uprs !== 1'b0)      begin n_err++; $display("FAIL wr_uprs c%0d: got %b want 0", c, uprs); end
      n_cmp++; if (cpu_ack !== (c == 6)) begin n_err++; $display("FAIL wr_ack c%0d: got %b want %b", c, cpu_ack, (c == 6)); end
      n_cmp++; if (cpu_busy !== 1'b1)  begin n_err++; $display("FAIL wr_busy c%0d: got %b want 1", c, cpu_busy); end
      if (c == 3) begin
        n_cmp++; if (upa !== 5'd5)          begin n_err++; $display("FAIL wr_upa: got %h want 05", upa); end
        n_cmp++; if (updi !== 32'hA5A5_0001) begin n_err++; $display("FAIL wr_updi: got %h want a5a50001", updi); end
      end
      if (c == 6) begin
        n_cmp++; if (cpu_toerr !== 1'b0) begin n_err++; $display("FAIL wr_toerr: got %b want 0", cpu_toerr); end
        n_cmp++; if (cpu_rdata !== '0)   begin n_err++; $display("FAIL wr_rdata: got %h want 0", cpu_rdata); end
      end
    end
    step();
    idle_inputs();
    n_cmp++; if ({cpu_ack, cpu_busy} !== 2'b00) begin n_err++; $display("FAIL wr_after: got %b want 00", {cpu_ack, cpu_busy}); end
  endtask

  task automatic test_read();
    logic [3:0] exp_upen;
    updo = {32'hDEAD_BEEF, 32'hCAFE_F00D, 32'h1234_5678, 32'h55AA_55AA};
    cpu_req = 1'b1; cpu_wr = 1'b0; cpu_regsel = 1'b0; cpu_addr = {2'd1, 5'd9};
    for (int c = 1; c <= 6; c++) begin
      step();
      idle_inputs();
      uprdy    = (c == 3) ? 4'b1000 : (c == 4) ? 4'b0010 : 4'b0000;
      exp_upen = (c <= 4) ? 4'b0010 : 4'b0000;
      n_cmp++; if (upen !== exp_upen) begin n_err++; $display("FAIL rd_upen c%0d: got %b want %b", c, upen, exp_upen); end
      n_cmp++; if (uprs !== (c == 1)) begin n_err++; $display("FAIL rd_uprs c%0d: got %b want %b", c, uprs, (c == 1)); end
      n_cmp++; if (upws !== 1'b0)     begin n_err++; $display("FAIL rd_upws c%0d: got %b want 0", c, upws); end
      n_cmp++; if (cpu_ack !== (c == 5)) begin n_err++; $display("FAIL rd_ack c%0d: got %b want %b", c, cpu_ack, (c == 5)); end
      if (c == 4) begin
        n_cmp++; if (cpu_rdata !== '0) begin n_err++; $display("FAIL rd_rdata_idle: got %h want 0", cpu_rdata); end
      end
      if (c == 5) begin
        n_cmp++; if (cpu_rdata !== 32'h1234_5678) begin n_err++; $display("FAIL rd_rdata: got %h want 12345678", cpu_rdata); end
        n_cmp++; if (cpu_toerr !== 1'b0) begin n_err++; $display("FAIL rd_toerr: got %b want 0", cpu_toerr); end
        // A request in the ack cycle must be dropped.
        cpu_req = 1'b1; cpu_regsel = 1'b1;
      end
      if (c == 6) begin
        n_cmp++; if (cpu_busy !== 1'b0) begin n_err++; $display("FAIL rd_req_in_ack_busy: got %b want 0", cpu_busy); end
      end
    end
    step();
    n_cmp++; if (cpu_ack !== 1'b0) begin n_err++; $display("FAIL rd_req_in_ack_ack: got %b want 0", cpu_ack); end
  endtask

  task automatic test_timeout();
    int early_acks;
    early_acks = 0;
    cpu_req = 1'b1; cpu_wr = 1'b0; cpu_regsel = 1'b0; cpu_addr = {2'd0, 5'd3};
    for (int c = 1; c <= 65; c++) begin
      step();
      idle_inputs();
      if (c <= 64 && cpu_ack !== 1'b0) early_acks++;
      if (c == 64) begin
        n_cmp++; if (upen !== 4'b0001) begin n_err++; $display("FAIL to_upen_c64: got %b want 0001", upen); end
      end
    end
    n_cmp++; if (early_acks !== 0)     begin n_err++; $display("FAIL to_early_ack: got %0d want 0", early_acks); end
    n_cmp++; if (cpu_ack !== 1'b1)     begin n_err++; $display("FAIL to_ack_c65: got %b want 1", cpu_ack); end
    n_cmp++; if (cpu_toerr !== 1'b1)   begin n_err++; $display("FAIL to_toerr_c65: got %b want 1", cpu_toerr); end
    n_cmp++; if (cpu_rdata !== '0)     begin n_err++; $display("FAIL to_rdata_c65: got %h want 0", cpu_rdata); end
    n_cmp++; if (upen !== 4'b0000)     begin n_err++; $display("FAIL to_upen_c65: got %b want 0000", upen); end
    step();
    n_cmp++; if ({cpu_ack, cpu_toerr, cpu_busy} !== 3'b000)
      begin n_err++; $display("FAIL to_after: got %b want 000", {cpu_ack, cpu_toerr, cpu_busy}); end
  endtask

  task automatic test_sticky();
    parerr = 4'b1001;
    step();
    parerr = 4'b0000;
    n_cmp++; if (parerr_any !== 1'b1) begin n_err++; $display("FAIL stk_any_set: got %b want 1", parerr_any); end
    reg_op(1'b0, '0, 4'b0000);
    n_cmp++; if (cpu_ack !== 1'b1)       begin n_err++; $display("FAIL stk_rd1_ack: got %b want 1", cpu_ack); end
    n_cmp++; if (cpu_rdata !== 32'h9)    begin n_err++; $display("FAIL stk_rd1_data: got %h want 9", cpu_rdata); end
    n_cmp++; if (upen !== 4'b0000)       begin n_err++; $display("FAIL stk_rd1_upen: got %b want 0000", upen); end
    step();
    // Clear bit 3 while parerr[3] pulses: set must win, bit 0 untouched.
    reg_op(1'b1, 32'h8, 4'b1000);
    n_cmp++; if (cpu_ack !== 1'b1)       begin n_err++; $display("FAIL stk_wr1_ack: got %b want 1", cpu_ack); end
    n_cmp++; if (cpu_rdata !== '0)       begin n_err++; $display("FAIL stk_wr1_rdata: got %h want 0", cpu_rdata); end
    step();
    reg_op(1'b0, '0, 4'b0000);
    n_cmp++; if (cpu_rdata !== 32'h9)    begin n_err++; $display("FAIL stk_setwins: got %h want 9", cpu_rdata); end
    step();
    reg_op(1'b1, 32'h1, 4'b0000);
    step();
    reg_op(1'b0, '0, 4'b0000);
    n_cmp++; if (cpu_rdata !== 32'h8)    begin n_err++; $display("FAIL stk_clr_bit0: got %h want 8", cpu_rdata); end
    step();
    reg_op(1'b1, 32'h9, 4'b0000);
    step();
    reg_op(1'b0, '0, 4'b0000);
    n_cmp++; if (cpu_rdata !== '0)       begin n_err++; $display("FAIL stk_clr_all: got %h want 0", cpu_rdata); end
    n_cmp++; if (parerr_any !== 1'b0)    begin n_err++; $display("FAIL stk_any_clr: got %b want 0", parerr_any); end
    step();
  endtask

  task automatic test_drop_and_reset();
    int n_ack;
    int ack_cycle;
    n_ack = 0;
    ack_cycle = -1;
    cpu_req = 1'b1; cpu_wr = 1'b1; cpu_regsel = 1'b0; cpu_addr = {2'd3, 5'd1}; cpu_wdata = 32'h0000_00F0;
    for (int c = 1; c <= 10; c++) begin
      step();
      idle_inputs();
      if (c == 2) begin cpu_req = 1'b1; cpu_regsel = 1'b1; end
      if (c == 4) uprdy = 4'b1000;
      if (cpu_ack === 1'b1) begin n_ack++; ack_cycle = c; end
      if (c == 3) begin
        n_cmp++; if (cpu_busy !== 1'b1) begin n_err++; $display("FAIL drop_busy_c3: got %b want 1", cpu_busy); end
      end
    end
    n_cmp++; if (n_ack !== 1)     begin n_err++; $display("FAIL drop_ack_count: got %0d want 1", n_ack); end
    n_cmp++; if (ack_cycle !== 5) begin n_err++; $display("FAIL drop_ack_cycle: got %0d want 5", ack_cycle); end

    parerr = 4'b0010;
    step();
    parerr = 4'b0000;
    n_ack = 0;
    cpu_req = 1'b1; cpu_wr = 1'b0; cpu_regsel = 1'b0; cpu_addr = {2'd2, 5'd7};
    for (int c = 1; c <= 10; c++) begin
      step();
      idle_inputs();
      if (c == 3) begin
        n_cmp++; if (upen !== 4'b0100) begin n_err++; $display("FAIL rst_upen_c3: got %b want 0100", upen); end
        rst = 1'b1;
      end
      if (c == 4) begin
        n_cmp++; if (upen !== 4'b0000) begin n_err++; $display("FAIL rst_upen_c4: got %b want 0000", upen); end
        n_cmp++; if (cpu_busy !== 1'b0) begin n_err++; $display("FAIL rst_busy_c4: got %b want 0", cpu_busy); end
        n_cmp++; if (parerr_any !== 1'b0) begin n_err++; $display("FAIL rst_sticky_c4: got %b want 0", parerr_any); end
        rst = 1'b0;
      end
      if (c == 5) uprdy = 4'b0100;
      if (cpu_ack === 1'b1) n_ack++;
    end
    n_cmp++; if (n_ack !== 0) begin n_err++; $display("FAIL rst_no_ack: got %0d want 0", n_ack); end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_write();
    test_read();
    test_timeout();
    test_sticky();
    test_drop_and_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
